vga_sync_gen: RTL and testbench



---
 rtl/vga_sync_gen.sv | 96 +++++++++
 tb/tb_vga_sync_gen.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters, sync pulses,
// frame strobe and registered, blanked RGB output.
module vga_sync_gen #(
  parameter int HD      = 640,
  parameter int HF      = 16,
  parameter int HB      = 48,
  parameter int HR      = 96,
  parameter int VD      = 480,
  parameter int VF      = 10,
  parameter int VB      = 33,
  parameter int VR      = 2,
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] rgb_in,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       frame_tick,
  output logic [2:0] rgb_out
);

  // Counter limits; HMAX and VMAX must fit in the 10-bit counters.
  localparam logic [9:0] HMAX     = 10'(HD + HF + HB + HR - 1);
  localparam logic [9:0] VMAX     = 10'(VD + VF + VB + VR - 1);
  localparam logic [9:0] H_DISP   = 10'(HD);
  localparam logic [9:0] V_DISP   = 10'(VD);
  localparam logic [9:0] HS_START = 10'(HD + HF);
  localparam logic [9:0] HS_END   = 10'(HD + HF + HR - 1);
  localparam logic [9:0] VS_START = 10'(VD + VF);
  localparam logic [9:0] VS_END   = 10'(VD + VF + VR - 1);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] div_reg, div_next;
  logic [9:0]       h_count_reg, h_next;
  logic [9:0]       v_count_reg, v_next;
  logic             hsync_reg, vsync_reg;
  logic             frame_tick_reg;
  logic [2:0]       rgb_reg;
  logic             h_end, v_end;
  logic             tick;

  assign tick  = (div_reg == DIV_LAST) & reset;
  assign h_end = (h_count_reg == HMAX);
  assign v_end = (v_count_reg == VMAX);

  always_comb begin
    div_next = (div_reg == DIV_LAST) ? '0 : div_reg + DIV_ONE;
    h_next   = h_count_reg;
    v_next   = v_count_reg;
    if (tick) begin
      h_next = h_end ? 10'd0 : h_count_reg + 10'd1;
      if (h_end)
        v_next = v_end ? 10'd0 : v_count_reg + 10'd1;
    end
  end

  // Syncs are registered from the next-state counters so they align with pix_x/pix_y.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_reg        <= '0;
      h_count_reg    <= 10'd0;
      v_count_reg    <= 10'd0;
      hsync_reg      <= 1'b1;
      vsync_reg      <= 1'b1;
      frame_tick_reg <= 1'b0;
      rgb_reg        <= 3'b000;
    end else begin
      div_reg        <= div_next;
      h_count_reg    <= h_next;
      v_count_reg    <= v_next;
      hsync_reg      <= ~((h_next >= HS_START) && (h_next <= HS_END));
      vsync_reg      <= ~((v_next >= VS_START) && (v_next <= VS_END));
      frame_tick_reg <= tick & h_end & v_end;
      if (tick)
        rgb_reg <= video_on ? rgb_in : 3'b000;
    end
  end

  assign video_on   = (h_count_reg < H_DISP) && (v_count_reg < V_DISP);
  assign p_tick     = tick;
  assign pix_x      = h_count_reg;
  assign pix_y      = v_count_reg;
  assign hsync      = hsync_reg;
  assign vsync      = vsync_reg;
  assign frame_tick = frame_tick_reg;
  assign rgb_out    = rgb_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: two instances (CLK_DIV=2 and 1) on a
// shrunken raster, checked against a pixel-index model of the raster.
module tb_vga_sync_gen;

  localparam int HD = 16, HF = 4, HB = 6, HR = 8;
  localparam int VD = 10, VF = 2, VB = 3, VR = 2;
  localparam int HT = HD + HF + HB + HR;
  localparam int VT = VD + VF + VB + VR;
  localparam int NCYC = 4000;

  typedef struct {
    logic       hs;
    logic       vs;
    logic       von;
    logic       pt;
    logic       ft;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] rgb;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] rgb_in = 3'b000;

  logic [1:0] hs, vs, von, pt, ft;
  logic [9:0] px [2];
  logic [9:0] py [2];
  logic [2:0] ro [2];

  exp_t q0[$];
  exp_t q1[$];
  int   k [2];
  logic [2:0] rgb_e [2];
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      vga_sync_gen #(
        .HD(HD), .HF(HF), .HB(HB), .HR(HR),
        .VD(VD), .VF(VF), .VB(VB), .VR(VR),
        .CLK_DIV(gi + 1)
      ) dut (
        .clk(clk),
        .reset(reset),
        .rgb_in(rgb_in),
        .hsync(hs[gi]),
        .vsync(vs[gi]),
        .video_on(von[gi]),
        .p_tick(pt[gi]),
        .pix_x(px[gi]),
        .pix_y(py[gi]),
        .frame_tick(ft[gi]),
        .rgb_out(ro[gi])
      );
    end
  endgenerate

  function automatic logic visible(int p);
    return ((p % HT) < HD) && ((p / HT) < VD);
  endfunction

  // Expected outputs after kk clocks out of reset: pixel index = kk / d.
  function automatic exp_t model(int d, int kk, logic [2:0] rg, logic rst);
    exp_t e;
    int p, x, y;
    p = (kk / d) % (HT * VT);
    x = p % HT;
    y = p / HT;
    e.x   = 10'(x);
    e.y   = 10'(y);
    e.hs  = !((x >= HD + HF) && (x < HD + HF + HR));
    e.vs  = !((y >= VD + VF) && (y < VD + VF + VR));
    e.von = (x < HD) && (y < VD);
    e.pt  = rst && ((kk % d) == d - 1);
    e.ft  = (kk > 0) && ((kk % d) == 0) && (p == 0);
    e.rgb = rg;
    return e;
  endfunction

  task automatic step(int i, logic r_s, logic [2:0] g_s);
    int d;
    d = i + 1;
    if (!r_s) begin
      k[i]     = 0;
      rgb_e[i] = 3'b000;
    end else begin
      if ((k[i] % d) == d - 1)
        rgb_e[i] = visible((k[i] / d) % (HT * VT)) ? g_s : 3'b000;
      k[i] = k[i] + 1;
    end
  endtask

  task automatic chk(string name, int i, int act, int exp);
    total++;
    if (act == exp)
      passed++;
    else
      $display("FAIL %s dut%0d k=%0d: got %0d expected %0d", name, i, k[i], act, exp);
  endtask

  task automatic compare(int i, exp_t e);
    chk("hsync", i, int'(hs[i]), int'(e.hs));
    chk("vsync", i, int'(vs[i]), int'(e.vs));
    chk("video_on", i, int'(von[i]), int'(e.von));
    chk("p_tick", i, int'(pt[i]), int'(e.pt));
    chk("frame_tick", i, int'(ft[i]), int'(e.ft));
    chk("pix_x", i, int'(px[i]), int'(e.x));
    chk("pix_y", i, int'(py[i]), int'(e.y));
    chk("rgb_out", i, int'(ro[i]), int'(e.rgb));
  endtask

  // Monitor: every clk the DUTs present a full output set.
  initial begin
    forever begin
      @(negedge clk);
      if (q0.size() > 0) compare(0, q0.pop_front());
      if (q1.size() > 0) compare(1, q1.pop_front());
    end
  end

  // Stimulus: random colour every clk, 6-clk reset at start, a one-clk
  // mid-frame reset at cycle 700, and rare random resets.
  initial begin
    logic       r_s;
    logic [2:0] g_s;
    k[0] = 0; k[1] = 0;
    rgb_e[0] = 3'b000; rgb_e[1] = 3'b000;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      r_s = reset;
      g_s = rgb_in;
      step(0, r_s, g_s);
      step(1, r_s, g_s);
      #1;
      reset  = (c < 5 || c == 700 || $urandom_range(0, 1999) == 0) ? 1'b0 : 1'b1;
      rgb_in = (($urandom_range(0, 3) == 0) ? 3'b110 : 3'($urandom_range(0, 7)));
      q0.push_back(model(1, k[0], rgb_e[0], reset));
      q1.push_back(model(2, k[1], rgb_e[1], reset));
    end
    @(negedge clk);
    #1;
    if (q0.size() != 0 || q1.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d entries left, expected 0", q0.size() + q1.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
